// File: rtl/char_sequencer_if.sv
// ----------------------------------------------------------------------------
// char_sequencer_if
// Host-side bundle for char_sequencer.
//   master : host logic. Drives writes and playback controls, sees status.
//   slave  : the sequencer. Drives char/char_idx/count/full/wrap.
// Signals:
//   wr_en, wr_data  append one ASCII byte to the message buffer
//   clr             synchronous clear of the buffer; stops playback
//   run             level, 1 = play the message in a loop
//   dwell           ticks each character is shown (0 behaves as 1)
//   char            ASCII code to the decoder, 8'h00 = blank
//   char_idx        buffer index currently shown
//   count, full     number of stored characters, count == DEPTH
//   wrap            one-cycle pulse when playback returns to index 0
// ----------------------------------------------------------------------------
interface char_sequencer_if #(
   parameter int DEPTH = 8
);
   localparam int IW = $clog2(DEPTH);

   logic          wr_en;
   logic [7:0]    wr_data;
   logic          clr;
   logic          run;
   logic [3:0]    dwell;
   logic [7:0]    char;
   logic [IW-1:0] char_idx;
   logic [IW:0]   count;
   logic          full;
   logic          wrap;

   modport master (
      output wr_en, wr_data, clr, run, dwell,
      input  char, char_idx, count, full, wrap
   );

   modport slave (
      input  wr_en, wr_data, clr, run, dwell,
      output char, char_idx, count, full, wrap
   );
endinterface

// File: rtl/char_sequencer.sv
// ----------------------------------------------------------------------------
// char_sequencer
// Stores a short ASCII message and plays it back one character at a time on
// an 8-bit char bus for the seven-segment decoder. Each character is shown
// for max(dwell,1) ticks, then blanked for one tick so repeated letters stay
// distinguishable. The message loops while run is high.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    char_sequencer_if.slave (write port, controls, char output, status)
// Parameters:
//   DEPTH     message buffer entries (power of two, >= 2)
//   PRESCALE  clock cycles per timing tick (>= 1)
// ----------------------------------------------------------------------------
module char_sequencer #(
   parameter int DEPTH    = 8,
   parameter int PRESCALE = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   char_sequencer_if.slave  bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int CW = IW + 1;
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   typedef enum logic [1:0] {IDLE, SHOW, GAP} state_t;

   state_t        state_q, state_d;
   logic [7:0]    char_q, char_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          wrap_q, wrap_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    dcnt_q, dcnt_d;
   logic [3:0]    dwell_q, dwell_d;

   logic [7:0]    mem_q [DEPTH];

   logic          tick;
   logic          last;
   logic          wr_ok;
   logic [3:0]    dwell_eff;

   assign tick      = (presc_q == PW'(PRESCALE - 1));
   // Wrap decision uses the count visible at the GAP-exit edge, so bytes
   // appended during playback join the loop.
   assign last      = (CW'(idx_q) == count_q - CW'(1));
   assign wr_ok     = bus.wr_en && !full_q && !bus.clr;
   assign dwell_eff = (bus.dwell == 4'd0) ? 4'd1 : bus.dwell;

   // Buffer contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_ok) mem_q[count_q[IW-1:0]] <= bus.wr_data;
   end

   // State and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         char_q  <= 8'h00;
         idx_q   <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         wrap_q  <= 1'b0;
         presc_q <= '0;
         dcnt_q  <= 4'd0;
         dwell_q <= 4'd0;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         idx_q   <= idx_d;
         count_q <= count_d;
         full_q  <= full_d;
         wrap_q  <= wrap_d;
         presc_q <= presc_d;
         dcnt_q  <= dcnt_d;
         dwell_q <= dwell_d;
      end
   end

   // Next-state logic. clr beats run=0, which beats tick-driven moves.
   always_comb begin
      state_d = state_q;
      if (bus.clr) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: if (bus.run && count_q != '0) state_d = SHOW;
            SHOW: begin
               if (!bus.run)                               state_d = IDLE;
               else if (tick && dcnt_q == dwell_q - 4'd1)  state_d = GAP;
            end
            GAP: begin
               if (!bus.run)  state_d = IDLE;
               else if (tick) state_d = SHOW;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Output / datapath logic
   always_comb begin
      char_d  = char_q;
      idx_d   = idx_q;
      wrap_d  = 1'b0;
      presc_d = presc_q;
      dcnt_d  = dcnt_q;
      dwell_d = dwell_q;

      if (state_d == IDLE) begin
         char_d  = 8'h00;
         idx_d   = '0;
         presc_d = '0;
         dcnt_d  = 4'd0;
      end else if (state_q == IDLE) begin
         // Start of playback: no wrap pulse on the initial start.
         idx_d   = '0;
         char_d  = mem_q[0];
         presc_d = '0;
         dcnt_d  = 4'd0;
         dwell_d = dwell_eff;
      end else begin
         presc_d = tick ? '0 : presc_q + PW'(1);
         if (state_q == SHOW && state_d == GAP) begin
            char_d = 8'h00;
            dcnt_d = 4'd0;
         end else if (state_q == SHOW && tick) begin
            dcnt_d = dcnt_q + 4'd1;
         end else if (state_q == GAP && state_d == SHOW) begin
            idx_d   = last ? '0 : idx_q + IW'(1);
            wrap_d  = last;
            char_d  = mem_q[idx_d];
            dcnt_d  = 4'd0;
            dwell_d = dwell_eff;
         end
      end
   end

   // Buffer fill level
   always_comb begin
      count_d = count_q;
      if (bus.clr)    count_d = '0;
      else if (wr_ok) count_d = count_q + CW'(1);
      full_d = (count_d == CW'(DEPTH));
   end

   assign bus.char     = char_q;
   assign bus.char_idx = idx_q;
   assign bus.count    = count_q;
   assign bus.full     = full_q;
   assign bus.wrap     = wrap_q;
endmodule

// File: tb/tb_char_sequencer.sv
// ----------------------------------------------------------------------------
// tb_char_sequencer
// Directed bench for char_sequencer with DEPTH=8, PRESCALE=4. Inputs are
// driven 1 time unit after the rising edge and outputs are sampled there.
// ----------------------------------------------------------------------------
module tb_char_sequencer;
   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   logic [7:0] data [9];

   always #5 clk = ~clk;

   char_sequencer_if #(.DEPTH(8)) bus ();

   char_sequencer #(.DEPTH(8), .PRESCALE(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] d);
      bus.wr_en   = 1'b1;
      bus.wr_data = d;
      step();
      bus.wr_en   = 1'b0;
   endtask

   // n consecutive cycles of char c at index idx; wrap high only on the first
   // cycle when wrap_first is set.
   task automatic seg(input string tag, input logic [7:0] c, input int n,
                      input int idx, input bit wrap_first);
      for (int i = 0; i < n; i++) begin
         chk({tag, " char"}, bus.char, c);
         chk({tag, " idx"},  bus.char_idx, idx);
         chk({tag, " wrap"}, bus.wrap, (wrap_first && i == 0));
         step();
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_data = 8'h00;
      bus.clr     = 1'b0;
      bus.run     = 1'b0;
      bus.dwell   = 4'd2;
      #12;
      chk("rst char",  bus.char, 8'h00);
      chk("rst idx",   bus.char_idx, 0);
      chk("rst count", bus.count, 0);
      chk("rst full",  bus.full, 0);
      chk("rst wrap",  bus.wrap, 0);
      rst_n = 1'b1;
      step();

      // run with empty buffer stays blank; first write starts playback
      bus.run = 1'b1;
      step(); step(); step();
      chk("empty char",  bus.char, 8'h00);
      chk("empty count", bus.count, 0);
      wr(8'h41);
      chk("wr1 count", bus.count, 1);
      chk("wr1 char",  bus.char, 8'h00);
      step();
      chk("start char", bus.char, 8'h41);
      chk("start idx",  bus.char_idx, 0);
      chk("start wrap", bus.wrap, 0);

      // stop latency
      bus.run = 1'b0;
      step();
      chk("stop char", bus.char, 8'h00);
      chk("stop idx",  bus.char_idx, 0);

      // "ABC" with dwell=2: 8 show, 4 gap per char, wrap on return to A
      wr(8'h42);
      wr(8'h43);
      chk("abc count", bus.count, 3);
      bus.run = 1'b1;
      step();
      seg("A",   8'h41, 8, 0, 0);
      seg("gA",  8'h00, 4, 0, 0);
      seg("B",   8'h42, 8, 1, 0);
      seg("gB",  8'h00, 4, 1, 0);
      seg("C",   8'h43, 8, 2, 0);
      seg("gC",  8'h00, 4, 2, 0);
      seg("A2",  8'h41, 8, 0, 1);
      bus.run = 1'b0;
      step();
      chk("abc stop char", bus.char, 8'h00);

      // clr together with wr_en mid-SHOW; held run must not restart
      bus.run = 1'b1;
      step(); step();
      chk("pre-clr char", bus.char, 8'h41);
      bus.clr     = 1'b1;
      bus.wr_en   = 1'b1;
      bus.wr_data = 8'h5A;
      step();
      bus.clr   = 1'b0;
      bus.wr_en = 1'b0;
      chk("clr count", bus.count, 0);
      chk("clr char",  bus.char, 8'h00);
      chk("clr idx",   bus.char_idx, 0);
      chk("clr full",  bus.full, 0);
      step(); step();
      chk("clr hold char",  bus.char, 8'h00);
      chk("clr hold count", bus.count, 0);

      // fill to DEPTH, ninth write dropped
      bus.run = 1'b0;
      for (int k = 0; k < 9; k++) data[k] = 8'h61 + 8'(k);
      data[8] = 8'h5A;
      for (int k = 0; k < 8; k++) wr(data[k]);
      chk("fill count", bus.count, 8);
      chk("fill full",  bus.full, 1);
      wr(data[8]);
      chk("drop count", bus.count, 8);
      chk("drop full",  bus.full, 1);
      bus.dwell = 4'd1;
      bus.run   = 1'b1;
      step();
      for (int k = 0; k < 8; k++) begin
         seg("full show", data[k], 4, k, 0);
         seg("full gap",  8'h00,   4, k, 0);
      end
      seg("full wrap", data[0], 1, 0, 1);
      bus.run = 1'b0;
      step();

      // single char "E", dwell=0 acts as 1; dwell change mid-char is deferred
      bus.clr = 1'b1;
      step();
      bus.clr = 1'b0;
      chk("clr2 count", bus.count, 0);
      wr(8'h45);
      bus.dwell = 4'd0;
      bus.run   = 1'b1;
      step();
      seg("E0a", 8'h45, 2, 0, 0);
      bus.dwell = 4'd2;
      seg("E0b", 8'h45, 2, 0, 0);
      seg("gE0", 8'h00, 4, 0, 0);
      seg("E1",  8'h45, 8, 0, 1);
      seg("gE1", 8'h00, 4, 0, 0);
      seg("E2",  8'h45, 1, 0, 1);

      // async reset mid-GAP
      bus.run = 1'b0;
      step();
      bus.dwell = 4'd1;
      bus.run   = 1'b1;
      step();
      chk("pre-rst show", bus.char, 8'h45);
      step(); step(); step(); step(); step();
      chk("pre-rst gap", bus.char, 8'h00);
      chk("pre-rst cnt", bus.count, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst char",  bus.char, 8'h00);
      chk("arst idx",   bus.char_idx, 0);
      chk("arst count", bus.count, 0);
      chk("arst full",  bus.full, 0);
      chk("arst wrap",  bus.wrap, 0);
      #2 rst_n = 1'b1;
      step(); step();
      chk("post-rst char", bus.char, 8'h00);
      wr(8'h53);
      chk("refill char", bus.char, 8'h00);
      step();
      chk("restart char", bus.char, 8'h53);
      chk("restart idx",  bus.char_idx, 0);
      chk("restart wrap", bus.wrap, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/char_sequencer.md
# char_sequencer

Upstream feeder for the ASCII-to-seven-segment decoder. Holds a short message of ASCII bytes written by the host logic and plays it back one character at a time onto an 8-bit `char` bus, with a programmable dwell per character. A blank gap separates characters so repeated letters stay distinguishable. The message loops continuously while `run` is high.

## Interface
- `DEPTH`, 8: message buffer entries; power of two, minimum 2.
- `PRESCALE`, 1000: clock cycles per timing tick; minimum 1.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  append `wr_data` to the buffer this cycle.
- `wr_data`  in  8  ASCII byte to append.
- `clr`  in  1  synchronous buffer clear; stops playback.
- `run`  in  1  level; 1 = play the message, 0 = stop.
- `dwell`  in  4  ticks each character is shown; 0 is treated as 1.
- `char`  out  8  ASCII code to the decoder; 8'h00 = blank.
- `char_idx`  out  $clog2(DEPTH)  buffer index currently shown.
- `count`  out  $clog2(DEPTH)+1  number of stored characters.
- `full`  out  1  `count == DEPTH`.
- `wrap`  out  1  one-cycle pulse when playback returns to index 0.

## Operation
- Reset values: `char`=8'h00, `char_idx`=0, `count`=0, `full`=0, `wrap`=0, state IDLE, prescaler=0, dwell counter=0. Buffer contents are not reset.
- Buffer:
  - `wr_en` stores `wr_data` at index `count` and increments `count`.
  - A write while `full` is dropped and `count` holds.
  - Writes are legal in any state.
- `clr` takes priority over `wr_en` and `run` in the same cycle. It sets `count`=0, `char_idx`=0, state IDLE, `char`=8'h00.
- State machine:
  - IDLE: `char`=8'h00. Moves to SHOW when `run`=1 and `count`>0, with `char_idx`=0 and the prescaler zeroed.
  - SHOW: `char` = buf[`char_idx`]. After max(`dwell`,1) ticks, moves to GAP.
  - GAP: `char`=8'h00 for exactly 1 tick. Then:
    - if `char_idx` = `count`-1, `char_idx` goes to 0, `wrap` pulses, and the state returns to SHOW;
    - otherwise `char_idx` increments and the state returns to SHOW.
  - In SHOW or GAP, `run`=0 goes to IDLE on the next edge with `char_idx`=0.
- Tick: the prescaler counts 0..PRESCALE-1. The tick fires on the cycle it equals PRESCALE-1, then the prescaler returns to 0. The prescaler runs only in SHOW and GAP.
- `dwell` is sampled on entry to each SHOW. Changing it mid-character has no effect until the next character.
- Growing the message during playback: a character appended while playing is included. The wrap test uses the `count` value at the GAP-exit edge.

## Timing
- All outputs are registered.
- Write visibility: `count` and `full` update on the edge that samples `wr_en`.
- Start latency: in the cycle after the edge that samples `run`=1 (IDLE, `count`>0), `char` = buf[0].
- SHOW lasts exactly max(`dwell`,1)·PRESCALE cycles; GAP lasts exactly PRESCALE cycles.
- `wrap` is high for the single cycle in which `char_idx` first reads 0 after a wrap. It is not asserted on the initial start.
- Stop latency: `char`=8'h00 one cycle after the edge that samples `run`=0.
- `rst_n` assertion mid-playback forces all reset values immediately, without waiting for a clock edge.
- Single-entry message (`count`=1): the output alternates SHOW buf[0] and GAP, with `wrap` pulsing every period.

## Test plan
- Load "ABC" with PRESCALE=4, `dwell`=2, `run`=1:
  - `char` = 8'h41 for 8 cycles, 8'h00 for 4, 8'h42 for 8, 8'h00 for 4, 8'h43 for 8, 8'h00 for 4, then 8'h41.
  - `wrap`=1 for exactly 1 cycle on the return to 8'h41.
- Write 9 bytes with DEPTH=8: `count`=8 and `full`=1 after the 8th write; the 9th is dropped and buf[7] is unchanged.
- `dwell`=0, PRESCALE=4, single char "E": the pattern is 8'h45 for 4 cycles, 8'h00 for 4, repeating, with `wrap` pulsing every 8 cycles.
- Assert `clr` and `wr_en` together mid-SHOW: next cycle `count`=0, `char`=8'h00, state IDLE; `run`=1 held does not restart playback.
- `run`=1 with `count`=0: `char` stays 8'h00. The first write then starts playback, with `char`=buf[0] two cycles after the write edge.
- Pull `rst_n` low asynchronously mid-GAP: all outputs return to reset values before the next clock edge. After release, playback restarts from index 0 only when `run` is sampled high and the buffer is refilled.
